// File: rtl/multiplier_control.sv
// Sequencer for the add-shift multiplier datapath: one X/A clear, then WIDTH
// add/shift iterations, with an optional subtract on the last iteration for signed operands.
module multiplier_control #(
    parameter int WIDTH       = 8,
    parameter bit SIGNED_MODE = 1'b1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Run,
    input  logic                         ClearA_LoadB,
    input  logic                         M,
    output logic                         Clr_Ld,
    output logic                         Clr_XA,
    output logic                         Add,
    output logic                         Sub,
    output logic                         Shift_En,
    output logic                         Busy,
    output logic                         Done,
    output logic [$clog2(WIDTH+1)-1:0]   Iter
);
    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state;
    logic   last;

    assign last = (Iter == LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
            Iter  <= '0;
        end else begin
            case (state)
                S_IDLE:  if (Run) state <= S_CLEAR;
                S_CLEAR: begin
                    state <= S_ADD;
                    Iter  <= '0;
                end
                S_ADD:   state <= S_SHIFT;
                S_SHIFT: begin
                    Iter  <= Iter + IW'(1);
                    state <= last ? S_DONE : S_ADD;
                end
                // Waiting for Run to drop guarantees one multiply per Run assertion.
                S_DONE:  if (!Run) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        Clr_Ld   = 1'b0;
        Clr_XA   = 1'b0;
        Add      = 1'b0;
        Sub      = 1'b0;
        Shift_En = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            S_IDLE:  Clr_Ld = ClearA_LoadB & ~Run;
            S_CLEAR: begin
                Clr_XA = 1'b1;
                Busy   = 1'b1;
            end
            S_ADD: begin
                Busy = 1'b1;
                Add  = M & ~(SIGNED_MODE & last);
                Sub  = M & SIGNED_MODE & last;
            end
            S_SHIFT: begin
                Shift_En = 1'b1;
                Busy     = 1'b1;
            end
            S_DONE:  Done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multiplier_control.sv
// Bench for multiplier_control: a phase-count reference model plus an add-shift
// datapath model driven by the controller, with product checks through an expected queue.
module tb_multiplier_control;
    localparam int W   = 8;
    localparam bit SM  = 1'b1;
    localparam int IW  = $clog2(W + 1);
    localparam int W2  = 4;
    localparam int IW2 = $clog2(W2 + 1);

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;

    logic run = 1'b0, clab = 1'b0, run2 = 1'b0;
    logic m;
    logic clr_ld, clr_xa, add, sub, shift_en, busy, done;
    logic [IW-1:0] iter;
    logic clr_ld2, clr_xa2, add2, sub2, shift_en2, busy2, done2;
    logic [IW2-1:0] iter2;

    multiplier_control #(.WIDTH(W), .SIGNED_MODE(SM)) dut (
        .Clk(clk), .Reset(reset), .Run(run), .ClearA_LoadB(clab), .M(m),
        .Clr_Ld(clr_ld), .Clr_XA(clr_xa), .Add(add), .Sub(sub),
        .Shift_En(shift_en), .Busy(busy), .Done(done), .Iter(iter)
    );

    multiplier_control #(.WIDTH(W2), .SIGNED_MODE(1'b0)) dut2 (
        .Clk(clk), .Reset(reset), .Run(run2), .ClearA_LoadB(1'b0), .M(1'b1),
        .Clr_Ld(clr_ld2), .Clr_XA(clr_xa2), .Add(add2), .Sub(sub2),
        .Shift_En(shift_en2), .Busy(busy2), .Done(done2), .Iter(iter2)
    );

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // datapath model driven by the controller outputs
    logic [W-1:0] dp_s = '0, sw_b = '0, dp_a = '0, dp_b = '0;
    logic         dp_x = 1'b0;
    assign m = dp_b[0];

    function automatic logic [W:0] alu(input logic [W-1:0] a, input logic [W-1:0] s,
                                       input logic do_sub);
        logic [W:0] ea, es;
        ea = SM ? {a[W-1], a} : {1'b0, a};
        es = SM ? {s[W-1], s} : {1'b0, s};
        return do_sub ? (ea - es) : (ea + es);
    endfunction

    always @(posedge clk) begin
        if (clr_ld) begin
            dp_x <= 1'b0;
            dp_a <= '0;
            dp_b <= sw_b;
        end else if (clr_xa) begin
            dp_x <= 1'b0;
            dp_a <= '0;
        end else if (add || sub) begin
            {dp_x, dp_a} <= alu(dp_a, dp_s, sub);
        end else if (shift_en) begin
            dp_x <= SM ? dp_x : 1'b0;
            dp_a <= {dp_x, dp_a[W-1:1]};
            dp_b <= {dp_a[0], dp_b[W-1:1]};
        end
    end

    // reference model: ph = cycles since the operation started (0 = idle),
    // 1 = clear, 2..2W+1 = add/shift pairs, 2W+2 = done
    int ph  = 0;
    int mit = 0;
    always @(posedge clk) begin
        if (reset) begin
            ph  <= 0;
            mit <= 0;
        end else if (ph == 0) begin
            if (run) ph <= 1;
        end else if (ph < 2 * W + 2) begin
            ph  <= ph + 1;
            mit <= (ph - 1) / 2;
        end else if (!run) begin
            ph <= 0;
        end
    end

    function automatic logic [6+IW:0] model_out(input int p, input int it, input logic r,
                                                input logic c, input logic mb);
        logic cl, cx, ad, sb, sh, bz, dn, last;
        {cl, cx, ad, sb, sh, bz, dn, last} = '0;
        if (p == 0) begin
            cl = c & ~r;
        end else if (p == 1) begin
            cx = 1'b1;
            bz = 1'b1;
        end else if (p <= 2 * W + 1) begin
            bz = 1'b1;
            if (p % 2 == 0) begin
                last = ((p - 2) / 2 == W - 1);
                sb   = mb & SM & last;
                ad   = mb & ~(SM & last);
            end else begin
                sh = 1'b1;
            end
        end else begin
            dn = 1'b1;
        end
        return {cl, cx, ad, sb, sh, bz, dn, IW'(it)};
    endfunction

    logic [6+IW:0] exp_v, act_v;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_v = model_out(ph, mit, run, clab, m);
            act_v = {clr_ld, clr_xa, add, sub, shift_en, busy, done, iter};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got=%b required=%b (clr_ld clr_xa add sub shift busy done iter)",
                         $time, act_v, exp_v);
            end
        end
    end

    // scoreboard of expected products
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_prod;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int st_add, st_sub, st_shift, st_clrxa, st_done, st_subcyc, st_clrxa_cyc;
    int st_addmask, st_first_sh, st_last_sh;

    task automatic load_b(input logic [W-1:0] b);
        sw_b = b;
        clab = 1'b1;
        run  = 1'b0;
        @(negedge clk);
        check("clr_ld_idle", int'(clr_ld), 1);
        tick();
        clab = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] s, input logic [W-1:0] b, input int hold);
        logic signed [2*W-1:0] se_s, se_b, prod;
        int n_sh, held;
        load_b(b);
        dp_s = s;
        se_s = {{W{s[W-1]}}, s};
        se_b = {{W{b[W-1]}}, b};
        prod = se_s * se_b;
        exp_q.push_back(prod);
        run  = 1'b1;
        clab = 1'b1;
        @(negedge clk);
        check("clr_ld_run_priority", int'(clr_ld), 0);
        {st_add, st_sub, st_shift, st_clrxa, st_addmask} = '0;
        st_done = -1; st_subcyc = -1; st_clrxa_cyc = -1; st_first_sh = -1; st_last_sh = -1;
        for (int c = 1; c <= 4 * W + 8 && st_done < 0; c++) begin
            tick();
            clab = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (clr_xa) begin st_clrxa++; st_clrxa_cyc = c; end
            if (add) begin st_add++; st_addmask |= 1 << ((c - 2) / 2); end
            if (sub) begin st_sub++; st_subcyc = c; end
            if (shift_en) begin
                st_shift++;
                if (st_first_sh < 0) st_first_sh = c;
                st_last_sh = c;
            end
            if (done) st_done = c;
        end
        last_prod = {dp_a, dp_b};
        check("done_latency", st_done, 2 * W + 2);
        check("shift_count", st_shift, W);
        check("clr_xa_count", st_clrxa, 1);
        check("iter_at_done", int'(iter), W);
        check("product", int'(last_prod), int'(exp_q.pop_front()));
        n_sh = 0;
        held = 1;
        repeat (hold) begin
            tick();
            @(negedge clk);
            if (shift_en) n_sh++;
            if (!done) held = 0;
        end
        check("hold_no_shift", n_sh, 0);
        check("hold_done", held, 1);
        tick();
        run  = 1'b0;
        clab = 1'b0;
        tick();
        @(negedge clk);
        check("done_drop", int'(done), 0);
        tick();
    endtask

    task automatic reset_mid();
        load_b(8'h5A);
        dp_s = 8'h11;
        run  = 1'b1;
        repeat (9) tick();
        reset = 1'b1;
        run   = 1'b0;
        tick();
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_iter", int'(iter), 0);
        check("rst_shift_add_sub", int'({shift_en, add, sub}), 0);
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic run_dut2();
        int a2, s2, sh2, d2;
        {a2, s2, sh2} = '0;
        d2 = -1;
        run2 = 1'b1;
        for (int c = 1; c <= 30 && d2 < 0; c++) begin
            tick();
            @(negedge clk);
            if (add2) a2++;
            if (sub2) s2++;
            if (shift_en2) sh2++;
            if (done2) d2 = c;
        end
        check("w4_done_latency", d2, 10);
        check("w4_add_count", a2, 4);
        check("w4_sub_count", s2, 0);
        check("w4_shift_count", sh2, 4);
        check("w4_iter", int'(iter2), 4);
        run2 = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        check("reset_outputs", int'({clr_ld, clr_xa, add, sub, shift_en, busy, done}), 0);
        check("reset_iter", int'(iter), 0);
        tick();
        reset = 1'b0;
        tick();

        // B=0x07, S=5: adds on iterations 0..2, then a long Run hold after Done
        run_op(8'h05, 8'h07, 40);
        check("b07_clr_xa_cycle", st_clrxa_cyc, 1);
        check("b07_add_mask", st_addmask, 'h07);
        check("b07_sub_count", st_sub, 0);
        check("b07_first_shift", st_first_sh, 3);
        check("b07_last_shift", st_last_sh, 17);
        check("b07_product", int'(last_prod), 'h0023);

        // B=0x80, S=3: only the last iteration subtracts
        run_op(8'h03, 8'h80, 2);
        check("b80_add_count", st_add, 0);
        check("b80_sub_count", st_sub, 1);
        check("b80_sub_cycle", st_subcyc, 16);
        check("b80_product", int'(last_prod), 'hFE80);

        reset_mid();
        run_op(8'hF3, 8'h2D, 1);

        run_dut2();

        run_op(8'h80, 8'h80, 0);
        run_op(8'h7F, 8'hFF, 3);
        for (int k = 0; k < 20; k++)
            run_op(W'($urandom), W'($urandom), $urandom_range(0, 4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multiplier_control.md
Name: multiplier_control

Overview:
Parametrised sequencing FSM for the add-shift multiplier datapath.
- For each multiply it issues one clear of the X/A accumulator, then WIDTH add/shift iterations.
- In signed mode, the final iteration subtracts instead of adds.
- It sits between the top-level switch/button synchroniser and the shift-register/adder datapath, and generalises the fixed 4-count shift controller to any operand width.

Parameters:
- WIDTH, 8: operand width; number of add/shift iterations. Must be at least 2.
- SIGNED_MODE, 1: 1 means a set M bit on the last iteration asserts Sub instead of Add (two's-complement multiplier); 0 means unsigned, Add only.

Ports:
- Clk  in  1  clock
- Reset  in  1  reset
- Run  in  1  start request, level, already synchronised
- ClearA_LoadB  in  1  request to clear X/A and load B from switches
- M  in  1  current LSB of the B register (multiplier bit)
- Clr_Ld  out  1  clear X/A and load B (idle only)
- Clr_XA  out  1  clear X and A at start of run
- Add  out  1  A <= A + S this cycle
- Sub  out  1  A <= A - S this cycle
- Shift_En  out  1  shift X:A:B right one bit
- Busy  out  1  operation in progress (S_CLEAR, S_ADD, S_SHIFT)
- Done  out  1  result valid (S_DONE)
- Iter  out  $clog2(WIDTH+1)  completed shift count, 0..WIDTH

Behaviour:
Reset and clocking
- Reset is synchronous and active-high; clock is Clk.
- Reset forces state S_IDLE and Iter=0 at the next rising edge, overriding everything including mid-operation.
- After reset all outputs are 0, except Clr_Ld, which follows its idle rule.

States
- S_IDLE, S_CLEAR, S_ADD, S_SHIFT, S_DONE.
- State register and Iter counter are the only flops. Outputs are Moore, except Clr_Ld/Add/Sub, which also depend on inputs combinationally.

Transitions
- S_IDLE: Run=1 goes to S_CLEAR; otherwise stay.
- S_CLEAR: goes to S_ADD unconditionally; Iter <= 0.
- S_ADD: goes to S_SHIFT unconditionally.
- S_SHIFT: Iter <= Iter+1. If Iter == WIDTH-1, go to S_DONE; otherwise go to S_ADD.
- S_DONE: Run=0 goes to S_IDLE; otherwise stay. Holding Run never retriggers, so exactly one multiply per Run assertion.

Outputs per state
- S_IDLE: Clr_Ld = ClearA_LoadB & ~Run (Run has priority). All other outputs 0.
- S_CLEAR: Clr_XA=1, Busy=1.
- S_ADD: Busy=1.
  - last = (Iter == WIDTH-1).
  - Add = M & ~(SIGNED_MODE & last).
  - Sub = M & SIGNED_MODE & last.
  - Add and Sub are never both 1.
- S_SHIFT: Shift_En=1, Busy=1.
- S_DONE: Done=1.
- ClearA_LoadB is ignored in every state except S_IDLE.

Latency
- With Run sampled high at edge 0:
  - Clr_XA is high in cycle 1.
  - Iteration i has S_ADD in cycle 2+2i and S_SHIFT in cycle 3+2i.
  - Done rises in cycle 2*WIDTH+2 (WIDTH=8 gives 18).
- Exactly WIDTH Shift_En pulses and exactly one Clr_XA pulse per operation.

Widths and counter
- Iter never exceeds WIDTH.
- Iter keeps its final value (WIDTH) through S_DONE and S_IDLE until the next S_CLEAR.

Test Plan:
- WIDTH=8, SIGNED_MODE=1, model B=0x07 (M sequence 1,1,1,0,0,0,0,0), Run pulse held high:
  - Clr_XA in cycle 1 only.
  - Add high in iterations 0-2 only; Sub never.
  - Eight Shift_En pulses in cycles 3,5,...,17.
  - Done=1 from cycle 18; Iter=8.
- WIDTH=8, SIGNED_MODE=1, B=0x80: Add never; Sub=1 in cycle 16 only (iteration 7); product sign bit correct in datapath model.
- Run held high 40 cycles after Done: state remains S_DONE, no further Shift_En. Drop Run: Done=0 and S_IDLE next cycle. Reassert Run: a new operation starts.
- Reset asserted in cycle 9 (mid iteration 3):
  - From cycle 10: Busy=0, Iter=0, Shift_En/Add/Sub=0.
  - Later Run starts a full 8-iteration operation.
- In S_IDLE: ClearA_LoadB=1 with Run=0 gives Clr_Ld=1 in the same cycle. ClearA_LoadB=1 with Run=1 gives Clr_Ld=0. ClearA_LoadB=1 during S_ADD/S_SHIFT gives Clr_Ld=0.
- WIDTH=4, SIGNED_MODE=0, M tied 1: four Add pulses, zero Sub, four Shift_En pulses, Done from cycle 10.
